// File: rtl/delta_dram_responder.sv
// delta_dram_responder
// Word-addressed DRAM model behind the Delta accelerator's single-master port.
// Reads return data with a one-cycle DRAM_DataReady pulse. Writes commit when
// they are accepted and are acknowledged with a one-cycle DRAM_WriteDone pulse.
// Each pulse arrives a fixed, programmable latency after acceptance.
// A host backdoor preloads and reads back the store while the DRAM side is idle.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   DRAM_Read/Write         level requests, held until the matching pulse
//   DRAM_Address            byte address (word aligned, within DEPTH_WORDS)
//   DRAM_WriteData          write data
//   DRAM_ReadData           read data, valid in the DRAM_DataReady cycle only
//   DRAM_DataReady          read completion pulse
//   DRAM_WriteDone          write completion pulse
//   host_req/we/addr/wdata  backdoor access; host_ready accepts it this cycle
//   host_rdata              backdoor read data, valid the cycle after acceptance
//   err_flag                sticky misaligned / out-of-range indicator
//   rd_count, wr_count      accepted DRAM reads / writes since reset
//
// state   | meaning
// IDLE    | waiting for a DRAM request; host port may be served
// RD_WAIT | read accepted, counting down its latency
// RD_RESP | DRAM_DataReady / DRAM_ReadData presented
// WR_WAIT | write committed, counting down its latency
// WR_RESP | DRAM_WriteDone presented
module delta_dram_responder #(
    parameter int DEPTH_WORDS   = 65536,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           DRAM_Read,
    input  logic                           DRAM_Write,
    input  logic [31:0]                    DRAM_Address,
    input  logic [31:0]                    DRAM_WriteData,
    output logic [31:0]                    DRAM_ReadData,
    output logic                           DRAM_DataReady,
    output logic                           DRAM_WriteDone,
    input  logic                           host_req,
    input  logic                           host_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] host_addr,
    input  logic [31:0]                    host_wdata,
    output logic                           host_ready,
    output logic [31:0]                    host_rdata,
    output logic                           err_flag,
    output logic [31:0]                    rd_count,
    output logic [31:0]                    wr_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    logic [31:0] read_data_q, read_data_d;
    logic        data_ready_q, data_ready_d;
    logic        write_done_q, write_done_d;
    logic [31:0] host_rdata_q, host_rdata_d;
    logic        err_q, err_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic [AW-1:0] word;
    logic          addr_err;
    logic [31:0]   dram_rd_word;

    assign word         = DRAM_Address[AW+1:2];
    // Any bit above the word index makes the access out of range.
    assign addr_err     = (DRAM_Address[1:0] != 2'b00) || ((DRAM_Address >> (AW + 2)) != 32'd0);
    assign dram_rd_word = addr_err ? 32'd0 : mem[word];

    assign host_ready = host_req && (state_q == IDLE) && !DRAM_Read && !DRAM_Write;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_buf_d     = rd_buf_q;
        read_data_d  = 32'd0;
        data_ready_d = 1'b0;
        write_done_d = 1'b0;
        host_rdata_d = host_rdata_q;
        err_d        = err_q;
        rd_count_d   = rd_count_q;
        wr_count_d   = wr_count_q;
        mem_we       = 1'b0;
        mem_waddr    = word;
        mem_wdata    = DRAM_WriteData;

        case (state_q)
            IDLE: begin
                if (DRAM_Read) begin
                    rd_count_d = rd_count_q + 32'd1;
                    err_d      = err_q | addr_err;
                    rd_buf_d   = dram_rd_word;
                    cnt_d      = RD_LOAD;
                    if (READ_LATENCY == 1) begin
                        state_d      = RD_RESP;
                        data_ready_d = 1'b1;
                        read_data_d  = dram_rd_word;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end else if (DRAM_Write) begin
                    wr_count_d = wr_count_q + 32'd1;
                    err_d      = err_q | addr_err;
                    mem_we     = !addr_err;
                    cnt_d      = WR_LOAD;
                    if (WRITE_LATENCY == 1) begin
                        state_d      = WR_RESP;
                        write_done_d = 1'b1;
                    end else begin
                        state_d = WR_WAIT;
                    end
                end else if (host_ready) begin
                    if (host_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = host_addr;
                        mem_wdata = host_wdata;
                    end else begin
                        host_rdata_d = mem[host_addr];
                    end
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = RD_RESP;
                    data_ready_d = 1'b1;
                    read_data_d  = rd_buf_q;
                end
            end
            WR_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d      = WR_RESP;
                    write_done_d = 1'b1;
                end
            end
            RD_RESP: state_d = IDLE;
            WR_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            rd_buf_q     <= 32'd0;
            read_data_q  <= 32'd0;
            data_ready_q <= 1'b0;
            write_done_q <= 1'b0;
            host_rdata_q <= 32'd0;
            err_q        <= 1'b0;
            rd_count_q   <= 32'd0;
            wr_count_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_buf_q     <= rd_buf_d;
            read_data_q  <= read_data_d;
            data_ready_q <= data_ready_d;
            write_done_q <= write_done_d;
            host_rdata_q <= host_rdata_d;
            err_q        <= err_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // Storage is never cleared; a write is only blocked in the reset cycle itself.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign DRAM_ReadData  = read_data_q;
    assign DRAM_DataReady = data_ready_q;
    assign DRAM_WriteDone = write_done_q;
    assign host_rdata     = host_rdata_q;
    assign err_flag       = err_q;
    assign rd_count       = rd_count_q;
    assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_delta_dram_responder.sv
module tb_delta_dram_responder;

    localparam int DEPTH = 65536;
    localparam int AW    = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          DRAM_Read, DRAM_Write;
    logic [31:0]   DRAM_Address, DRAM_WriteData, DRAM_ReadData;
    logic          DRAM_DataReady, DRAM_WriteDone;
    logic          host_req, host_we, host_ready;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_wdata, host_rdata;
    logic          err_flag;
    logic [31:0]   rd_count, wr_count;

    delta_dram_responder #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut (
        .clock(clock), .reset(reset),
        .DRAM_Read(DRAM_Read), .DRAM_Write(DRAM_Write),
        .DRAM_Address(DRAM_Address), .DRAM_WriteData(DRAM_WriteData),
        .DRAM_ReadData(DRAM_ReadData), .DRAM_DataReady(DRAM_DataReady),
        .DRAM_WriteDone(DRAM_WriteDone),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
        .err_flag(err_flag), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          at_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_resp(input bit is_rd, input logic [31:0] data, input int at_cyc);
        exp_t e;
        e.is_rd  = is_rd;
        e.data   = data;
        e.at_cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (DRAM_DataReady || DRAM_WriteDone) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: rd=%0b wr=%0b with nothing pending (cycle %0d)",
                         DRAM_DataReady, DRAM_WriteDone, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, DRAM_DataReady}, {31'd0, e.is_rd});
                check("pulse_cycle", cyc, e.at_cyc);
                if (e.is_rd) check("read_data", DRAM_ReadData, e.data);
            end
        end
    end

    // Returns at the negedge of the pulse cycle, or flags a timeout.
    task automatic wait_pulse(input bit is_rd);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (is_rd ? DRAM_DataReady : DRAM_WriteDone) got = 1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL pulse_timeout: no %s pulse within 20 cycles (cycle %0d)",
                     is_rd ? "read" : "write", cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
        step();
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1 check("host_ready_wr", {31'd0, host_ready}, 32'd1);
        step();
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, input logic [31:0] d);
        step();
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        #1 check("host_ready_rd", {31'd0, host_ready}, 32'd1);
        step();
        host_req = 1'b0;
        check("host_rdata", host_rdata, d);
    endtask

    initial begin
        int pulses;
        bit got;
        reset = 1'b1;
        DRAM_Read = 0; DRAM_Write = 0; DRAM_Address = 0; DRAM_WriteData = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        repeat (3) step();
        check("rst_data_ready", {31'd0, DRAM_DataReady}, 32'd0);
        check("rst_write_done", {31'd0, DRAM_WriteDone}, 32'd0);
        check("rst_read_data", DRAM_ReadData, 32'd0);
        check("rst_host_rdata", host_rdata, 32'd0);
        check("rst_err", {31'd0, err_flag}, 32'd0);
        check("rst_rd_count", rd_count, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        reset = 1'b0;

        // Preload through the backdoor.
        host_write(16'd5, 32'hDEADBEEF);
        host_write(16'd0, 32'h0BADF00D);

        // Read latency.
        step();
        DRAM_Read = 1; DRAM_Address = 32'h14;
        expect_resp(1, 32'hDEADBEEF, cyc + 4);
        wait_pulse(1);
        DRAM_Read = 0;
        check("rd_count_1", rd_count, 32'd1);

        // Write, then retarget to a read of the same address during WriteDone.
        step();
        DRAM_Write = 1; DRAM_Address = 32'h40; DRAM_WriteData = 32'h12345678;
        expect_resp(0, 32'd0, cyc + 4);
        wait_pulse(0);
        DRAM_Write = 0; DRAM_Read = 1;
        expect_resp(1, 32'h12345678, cyc + 5);
        wait_pulse(1);
        DRAM_Read = 0;

        // Simultaneous read and write: read first, write accepted right after.
        do_reset();
        check("rst2_rd_count", rd_count, 32'd0);
        DRAM_Read = 1; DRAM_Write = 1; DRAM_Address = 32'h0; DRAM_WriteData = 32'hA5A50004;
        expect_resp(1, 32'h0BADF00D, cyc + 4);
        wait_pulse(1);
        DRAM_Read = 0; DRAM_Address = 32'h4;
        expect_resp(0, 32'd0, cyc + 5);
        wait_pulse(0);
        DRAM_Write = 0;
        check("sim_rd_count", rd_count, 32'd1);
        check("sim_wr_count", wr_count, 32'd1);
        check("sim_err_clear", {31'd0, err_flag}, 32'd0);

        // Errors: misaligned read, out-of-range write (would alias word 0).
        step();
        DRAM_Read = 1; DRAM_Address = 32'h3;
        expect_resp(1, 32'd0, cyc + 4);
        wait_pulse(1);
        DRAM_Read = 0;
        step();
        check("err_after_read", {31'd0, err_flag}, 32'd1);
        DRAM_Write = 1; DRAM_Address = DEPTH * 4; DRAM_WriteData = 32'hFFFFFFFF;
        expect_resp(0, 32'd0, cyc + 4);
        wait_pulse(0);
        DRAM_Write = 0;
        host_read(16'd0, 32'h0BADF00D);
        host_read(16'd1, 32'hA5A50004);
        host_read(16'd16, 32'h12345678);
        check("err_sticky", {31'd0, err_flag}, 32'd1);
        check("err_rd_count", rd_count, 32'd2);
        check("err_wr_count", wr_count, 32'd2);

        // Host arbitration against a held DRAM read.
        step();
        DRAM_Read = 1; DRAM_Address = 32'h14;
        host_req = 1; host_we = 0; host_addr = 16'd5;
        expect_resp(1, 32'hDEADBEEF, cyc + 4);
        #1 check("host_blocked_0", {31'd0, host_ready}, 32'd0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            check("host_blocked", {31'd0, host_ready}, 32'd0);
            if (DRAM_DataReady) got = 1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL arb_timeout: no read pulse within 20 cycles (cycle %0d)", cyc);
        end
        DRAM_Read = 0;
        step();
        check("host_granted", {31'd0, host_ready}, 32'd1);
        step();
        host_req = 0;
        check("host_arb_rdata", host_rdata, 32'hDEADBEEF);

        // Reset two cycles after a read is accepted.
        do_reset();
        DRAM_Read = 1; DRAM_Address = 32'h14;
        step();
        step();
        reset = 1; DRAM_Read = 0;
        step();
        reset = 0;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (DRAM_DataReady) pulses++;
        end
        check("abandoned_pulses", pulses, 32'd0);
        check("abandoned_rd_count", rd_count, 32'd0);
        check("abandoned_wr_count", wr_count, 32'd0);
        host_read(16'd5, 32'hDEADBEEF);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
